// File: rtl/npc_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : npc_bus_pkg
// Description : Shared types and constants for the NPC memory arbiter slice:
//               sequencer state encoding, owner encodings, the latched
//               request record and the timeout-counter width helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package npc_bus_pkg;

    // Widths of the NPC core memory bus; the request record is sized to these.
    localparam int NPC_ADDR_W = 32;
    localparam int NPC_DATA_W = 32;
    localparam int NPC_STRB_W = NPC_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    typedef struct packed {
        logic [NPC_ADDR_W-1:0] addr;
        logic                  wen;
        logic [NPC_DATA_W-1:0] wdata;
        logic [NPC_STRB_W-1:0] wstrb;
    } npc_req_t;

    // Counter must hold 0..TIMEOUT_CYCLES-1; a disabled timeout still needs 1 bit.
    function automatic int cnt_width(input int timeout_cycles);
        if (timeout_cycles < 1) begin
            return 1;
        end
        return $clog2(timeout_cycles + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/npc_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : npc_mem_arbiter_if
// Description : Bundle of every handshake/bus signal around the arbiter:
//               IFU request side, LSU request side, shared response, slave
//               memory port and the owner indication.
//               slave  : view of the arbiter itself (serves IFU/LSU requests)
//               master : view of the environment (core masters + memory)
// Revision    : 1.0 - initial release
// ============================================================================
interface npc_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic              ifu_req_valid;
    logic              ifu_req_ready;
    logic [ADDR_W-1:0] ifu_addr;
    logic              ifu_resp_valid;

    logic              lsu_req_valid;
    logic              lsu_req_ready;
    logic [ADDR_W-1:0] lsu_addr;
    logic              lsu_wen;
    logic [DATA_W-1:0] lsu_wdata;
    logic [STRB_W-1:0] lsu_wstrb;
    logic              lsu_resp_valid;

    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wen;
    logic [DATA_W-1:0] mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_resp_err;

    logic              owner;

    modport slave (
        input  ifu_req_valid, ifu_addr,
        input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wstrb,
        input  mem_req_ready, mem_resp_valid, mem_rdata, mem_resp_err,
        output ifu_req_ready, ifu_resp_valid,
        output lsu_req_ready, lsu_resp_valid,
        output resp_rdata, resp_err,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb,
        output owner
    );

    modport master (
        output ifu_req_valid, ifu_addr,
        output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wstrb,
        output mem_req_ready, mem_resp_valid, mem_rdata, mem_resp_err,
        input  ifu_req_ready, ifu_resp_valid,
        input  lsu_req_ready, lsu_resp_valid,
        input  resp_rdata, resp_err,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb,
        input  owner
    );

endinterface
`default_nettype wire

// File: rtl/npc_rr_pick2.sv
`default_nettype none
// ============================================================================
// Module      : npc_rr_pick2
// Description : Two-requester round-robin selector. A lone requester wins;
//               on a tie the requester that was not granted last wins.
// Ports       : req[1:0]  in  request vector (bit 0 = IFU, bit 1 = LSU)
//               last      in  last granted owner (OWN_IFU / OWN_LSU)
//               gnt[1:0]  out one-hot grant, all-zero when nobody requests
// Revision    : 1.0 - initial release
// ============================================================================
module npc_rr_pick2
    import npc_bus_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    assign gnt[0] = req[0] & (~req[1] | (last == OWN_LSU));
    assign gnt[1] = req[1] & (~req[0] | (last == OWN_IFU));

endmodule
`default_nettype wire

// File: rtl/npc_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : npc_mem_arbiter
// Description : Shares one memory slave port between the IFU and the LSU.
//               One outstanding transaction at a time, round-robin on
//               contention, and a silent slave is answered with an error
//               response after TIMEOUT_CYCLES WAIT cycles (0 = never).
// Ports       : clk  in  system clock, rising edge
//               rst  in  asynchronous, active-low reset
//               bus  slave modport of npc_mem_arbiter_if (IFU/LSU requests,
//                    shared response, slave memory port, owner)
// Revision    : 1.0 - initial release
// ============================================================================
module npc_mem_arbiter
    import npc_bus_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst,
    npc_mem_arbiter_if.slave    bus
);

    localparam int            CW            = cnt_width(TIMEOUT_CYCLES);
    localparam int            STRB_W        = DATA_W / 8;
    localparam bit            c_timeout_en  = (TIMEOUT_CYCLES != 0);
    localparam logic [CW-1:0] c_cnt_last    = CW'(TIMEOUT_CYCLES - 1);

    state_t            r_state;
    logic              r_owner;
    npc_req_t          r_req;
    logic [CW-1:0]     r_cnt;
    logic              r_mem_req_valid;
    logic              r_ifu_resp_valid;
    logic              r_lsu_resp_valid;
    logic [DATA_W-1:0] r_resp_rdata;
    logic              r_resp_err;

    logic [1:0]        w_req;
    logic [1:0]        w_gnt;
    logic              w_idle;
    logic              w_expired;
    npc_req_t          w_win_req;

    assign w_req  = {bus.lsu_req_valid, bus.ifu_req_valid};
    assign w_idle = (r_state == IDLE);

    npc_rr_pick2 u_pick (
        .req  (w_req),
        .last (r_owner),
        .gnt  (w_gnt)
    );

    // Ready is gated by rst so nothing looks accepted while reset is held.
    assign bus.ifu_req_ready = rst & w_idle & w_gnt[0];
    assign bus.lsu_req_ready = rst & w_idle & w_gnt[1];

    // Fetches are always reads: write fields are forced to zero for the IFU.
    always_comb begin
        w_win_req = '0;
        if (w_gnt[1]) begin
            w_win_req.addr  = NPC_ADDR_W'(bus.lsu_addr);
            w_win_req.wen   = bus.lsu_wen;
            w_win_req.wdata = NPC_DATA_W'(bus.lsu_wdata);
            w_win_req.wstrb = NPC_STRB_W'(bus.lsu_wstrb);
        end else begin
            w_win_req.addr  = NPC_ADDR_W'(bus.ifu_addr);
        end
    end

    assign w_expired = c_timeout_en && (r_cnt == c_cnt_last);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state          <= IDLE;
            r_owner          <= OWN_IFU;
            r_req            <= '0;
            r_cnt            <= '0;
            r_mem_req_valid  <= 1'b0;
            r_ifu_resp_valid <= 1'b0;
            r_lsu_resp_valid <= 1'b0;
            r_resp_rdata     <= '0;
            r_resp_err       <= 1'b0;
        end else begin
            r_ifu_resp_valid <= 1'b0;
            r_lsu_resp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (|w_gnt) begin
                        r_req           <= w_win_req;
                        r_owner         <= w_gnt[1] ? OWN_LSU : OWN_IFU;
                        r_mem_req_valid <= 1'b1;
                        r_state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_cnt           <= '0;
                        r_state         <= WAIT;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt + CW'(1);
                    // A real response arriving in the expiry cycle takes priority.
                    if (bus.mem_resp_valid || w_expired) begin
                        r_resp_rdata     <= bus.mem_resp_valid ? bus.mem_rdata : '0;
                        r_resp_err       <= bus.mem_resp_valid ? bus.mem_resp_err : 1'b1;
                        r_ifu_resp_valid <= (r_owner == OWN_IFU);
                        r_lsu_resp_valid <= (r_owner == OWN_LSU);
                        r_state          <= RESP;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_req_valid  = r_mem_req_valid;
    assign bus.mem_addr       = ADDR_W'(r_req.addr);
    assign bus.mem_wen        = r_req.wen;
    assign bus.mem_wdata      = DATA_W'(r_req.wdata);
    assign bus.mem_wstrb      = STRB_W'(r_req.wstrb);
    assign bus.ifu_resp_valid = r_ifu_resp_valid;
    assign bus.lsu_resp_valid = r_lsu_resp_valid;
    assign bus.resp_rdata     = r_resp_rdata;
    assign bus.resp_err       = r_resp_err;
    assign bus.owner          = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_npc_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_npc_mem_arbiter
// Description : Self-checking bench for npc_mem_arbiter with a transaction-
//               level reference model (winner rule, latency arithmetic,
//               timeout rule) and directed plus randomized transactions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_npc_mem_arbiter;

    localparam int T = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    npc_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    npc_mem_arbiter #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference-model state: which master was granted last (0 = IFU, 1 = LSU).
    bit m_last = 1'b0;

    // Request fields presented by each master (held while pending).
    logic [31:0] ifu_a  = '0;
    logic [31:0] lsu_a  = '0;
    logic [31:0] lsu_wd = '0;
    logic        lsu_we = 1'b0;
    logic [3:0]  lsu_ws = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_quiet();
        bus.ifu_req_valid  = 1'b0;
        bus.ifu_addr       = '0;
        bus.lsu_req_valid  = 1'b0;
        bus.lsu_addr       = '0;
        bus.lsu_wen        = 1'b0;
        bus.lsu_wdata      = '0;
        bus.lsu_wstrb      = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = '0;
        bus.mem_resp_err   = 1'b0;
    endtask

    // One transaction, called at a negedge with the DUT idle.
    // rdly : cycles mem_req_ready is held low in ISSUE
    // pdly : WAIT cycle index of the slave response; >= T means never
    task automatic txn(input bit ifu_on, input bit lsu_on, input int rdly, input int pdly,
                       input logic [31:0] rd, input logic rerr, input string tag);
        bit          win;
        bit          real_resp;
        int          w;
        int          resp_c;
        logic [31:0] e_addr;
        logic [31:0] e_wd;
        logic        e_we;
        logic [3:0]  e_ws;
        logic [31:0] e_rd;
        logic        e_err;

        win       = (ifu_on && lsu_on) ? ~m_last : lsu_on;
        real_resp = (pdly < T);
        w         = real_resp ? pdly + 1 : T;
        resp_c    = rdly + w + 1;
        e_addr    = win ? lsu_a  : ifu_a;
        e_wd      = win ? lsu_wd : 32'h0;
        e_we      = win ? lsu_we : 1'b0;
        e_ws      = win ? lsu_ws : 4'h0;
        e_rd      = real_resp ? rd   : 32'h0;
        e_err     = real_resp ? rerr : 1'b1;

        bus.ifu_req_valid = ifu_on;
        bus.ifu_addr      = ifu_a;
        bus.lsu_req_valid = lsu_on;
        bus.lsu_addr      = lsu_a;
        bus.lsu_wen       = lsu_we;
        bus.lsu_wdata     = lsu_wd;
        bus.lsu_wstrb     = lsu_ws;
        #1;
        check({tag, ".ifu_ready"}, bus.ifu_req_ready, !win);
        check({tag, ".lsu_ready"}, bus.lsu_req_ready, win);
        @(posedge clk);
        m_last = win;

        for (int c = 0; c <= resp_c + 1; c++) begin
            @(negedge clk);
            check({tag, ".mem_req_valid"}, bus.mem_req_valid, c <= rdly);
            if (c <= rdly) begin
                check({tag, ".mem_addr"},  bus.mem_addr,  e_addr);
                check({tag, ".mem_wen"},   bus.mem_wen,   e_we);
                check({tag, ".mem_wdata"}, bus.mem_wdata, e_wd);
                check({tag, ".mem_wstrb"}, bus.mem_wstrb, e_ws);
            end
            check({tag, ".owner"}, bus.owner, win);
            check({tag, ".ifu_resp_valid"}, bus.ifu_resp_valid, (c == resp_c) && !win);
            check({tag, ".lsu_resp_valid"}, bus.lsu_resp_valid, (c == resp_c) && win);
            if (c <= resp_c) begin
                check({tag, ".ready_busy"}, {bus.ifu_req_ready, bus.lsu_req_ready}, 2'b00);
            end
            if (c >= resp_c) begin
                check({tag, ".resp_rdata"}, bus.resp_rdata, e_rd);
                check({tag, ".resp_err"},   bus.resp_err,   e_err);
            end
            if (c == 0) begin
                if (win) bus.lsu_req_valid = 1'b0;
                else     bus.ifu_req_valid = 1'b0;
            end
            bus.mem_req_ready  = (c == rdly);
            bus.mem_resp_valid = real_resp && (c == rdly + 1 + pdly);
            bus.mem_rdata      = bus.mem_resp_valid ? rd : $urandom;
            bus.mem_resp_err   = bus.mem_resp_valid ? rerr : 1'b0;
        end
        bus.mem_resp_valid = 1'b0;
    endtask

    initial begin
        bit          p_i;
        bit          p_l;
        bit          ion;
        bit          lon;
        bit          win;

        // ---------------- reset state (IFU requesting while in reset) ----------
        drive_quiet();
        bus.ifu_req_valid = 1'b1;
        bus.lsu_req_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("rst.ready", {bus.ifu_req_ready, bus.lsu_req_ready}, 2'b00);
        check("rst.mem_req_valid", bus.mem_req_valid, 1'b0);
        check("rst.resp_valid", {bus.ifu_resp_valid, bus.lsu_resp_valid}, 2'b00);
        check("rst.mem_addr", bus.mem_addr, 32'h0);
        check("rst.resp_rdata", bus.resp_rdata, 32'h0);
        check("rst.owner", bus.owner, 1'b0);
        drive_quiet();
        rst = 1'b1;
        m_last = 1'b0;
        @(negedge clk);

        // ---------------- IFU alone, minimum latency ----------------
        ifu_a = 32'h8000_0000;
        txn(1'b1, 1'b0, 0, 0, 32'h0010_0073, 1'b0, "ifu_read");

        // ---------------- contention: LSU, IFU, LSU, IFU ----------------
        ifu_a = 32'h8000_0004;
        lsu_a = 32'h8000_2000; lsu_we = 1'b0; lsu_wd = '0; lsu_ws = '0;
        txn(1'b1, 1'b1, 0, 0, 32'h1111_1111, 1'b0, "tie1");
        txn(1'b1, 1'b0, 0, 1, 32'h2222_2222, 1'b0, "tie2");
        txn(1'b1, 1'b1, 1, 0, 32'h3333_3333, 1'b0, "tie3");
        txn(1'b1, 1'b0, 0, 0, 32'h4444_4444, 1'b0, "tie4");

        // ---------------- LSU write with slave stalling ready ----------------
        lsu_a = 32'h8000_1000; lsu_we = 1'b1; lsu_wd = 32'hDEAD_BEEF; lsu_ws = 4'h3;
        txn(1'b0, 1'b1, 3, 1, 32'h0, 1'b0, "lsu_write");

        // ---------------- timeout, then stray response ----------------
        ifu_a = 32'h8000_0010;
        txn(1'b1, 1'b0, 0, T, 32'h5555_5555, 1'b0, "timeout");
        @(negedge clk);
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'h1234_5678;
        bus.mem_resp_err   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.mem_resp_valid = 1'b0;
            check("stray.resp_valid", {bus.ifu_resp_valid, bus.lsu_resp_valid}, 2'b00);
            check("stray.resp_rdata", bus.resp_rdata, 32'h0);
            check("stray.resp_err", bus.resp_err, 1'b1);
            check("stray.mem_req_valid", bus.mem_req_valid, 1'b0);
        end

        // ---------------- slave error passthrough ----------------
        ifu_a = 32'h8000_0020;
        txn(1'b1, 1'b0, 0, 2, 32'hCAFE_F00D, 1'b1, "slave_err");

        // ---------------- asynchronous reset during WAIT ----------------
        lsu_a = 32'h8000_3000; lsu_we = 1'b1; lsu_wd = 32'hA5A5_A5A5; lsu_ws = 4'hF;
        bus.lsu_req_valid = 1'b1;
        bus.lsu_addr = lsu_a; bus.lsu_wen = lsu_we; bus.lsu_wdata = lsu_wd; bus.lsu_wstrb = lsu_ws;
        @(posedge clk);
        @(negedge clk);
        bus.lsu_req_valid = 1'b0;
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        check("pre_rst.owner", bus.owner, 1'b1);
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr = 32'h8000_0040;
        #2;
        rst = 1'b0;
        #1;
        check("arst.ready", {bus.ifu_req_ready, bus.lsu_req_ready}, 2'b00);
        check("arst.mem_req_valid", bus.mem_req_valid, 1'b0);
        check("arst.resp_valid", {bus.ifu_resp_valid, bus.lsu_resp_valid}, 2'b00);
        check("arst.mem_addr", bus.mem_addr, 32'h0);
        check("arst.mem_wdata", bus.mem_wdata, 32'h0);
        check("arst.resp_rdata", bus.resp_rdata, 32'h0);
        check("arst.resp_err", bus.resp_err, 1'b0);
        check("arst.owner", bus.owner, 1'b0);
        bus.ifu_req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        m_last = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata = 32'h7777_7777;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bus.mem_resp_valid = 1'b0;
            check("post_rst.resp_valid", {bus.ifu_resp_valid, bus.lsu_resp_valid}, 2'b00);
        end
        ifu_a = 32'h8000_0044;
        txn(1'b1, 1'b0, 0, 0, 32'h8888_8888, 1'b0, "post_rst");

        // ---------------- randomized transactions ----------------
        p_i = 1'b0;
        p_l = 1'b0;
        for (int k = 0; k < 40; k++) begin
            ion = p_i | ($urandom_range(1, 0) == 1);
            lon = p_l | ($urandom_range(1, 0) == 1);
            if (!ion && !lon) begin
                if ($urandom_range(1, 0) == 1) lon = 1'b1;
                else                           ion = 1'b1;
            end
            if (!p_i) ifu_a = $urandom & 32'hFFFF_FFFC;
            if (!p_l) begin
                lsu_a  = $urandom;
                lsu_we = 1'($urandom_range(1, 0));
                lsu_wd = $urandom;
                lsu_ws = 4'($urandom_range(15, 0));
            end
            win = (ion && lon) ? ~m_last : lon;
            p_i = ion && win;
            p_l = lon && !win;
            txn(ion, lon, $urandom_range(3, 0), $urandom_range(5, 0), $urandom,
                ($urandom_range(7, 0) == 0), "rand");
        end
        if (p_i || p_l) begin
            txn(p_i, p_l, 0, 0, 32'h9999_9999, 1'b0, "drain");
        end
        drive_quiet();
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
